// File: rtl/uart_tx_port_pkg.sv
// uart_tx_port_pkg
// Shared definitions for the UART transmitter peripheral: register offsets
// (decoded from Address[3:2]), STATUS bit positions and the frame-engine
// state enumeration.
package uart_tx_port_pkg;

  // Register offsets, Address[3:2]
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  // Frame engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } frame_state_e;

endpackage

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if
// Data-bus link between the memory map decoder (master) and the UART
// transmitter (slave).
//   Address  : byte address, only [3:2] decoded by the UART
//   DataIn   : write data from the processor
//   DataOut  : read data back toward the decoder
//   Select   : chip select
//   MemWrite : write strobe
//   MemRead  : read strobe
interface uart_tx_port_if #(
  parameter int DATA_LENGTH = 32
);
  logic [DATA_LENGTH-1:0] Address;
  logic [DATA_LENGTH-1:0] DataIn;
  logic [DATA_LENGTH-1:0] DataOut;
  logic                   Select;
  logic                   MemWrite;
  logic                   MemRead;

  modport master (
    output Address, DataIn, Select, MemWrite, MemRead,
    input  DataOut
  );

  modport slave (
    input  Address, DataIn, Select, MemWrite, MemRead,
    output DataOut
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO with fall-through read data.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (dropped when full)
//   pop/dout : read request and head-of-queue data (ignored when empty)
//   full, empty, count : occupancy, all registered-state derived
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port
// Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA are queued
// in a small FIFO and serialized on tx at DIV clock cycles per bit.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : data-bus slave (Address/DataIn/DataOut/Select/MemWrite/MemRead)
//   tx       : serial line, idle high, registered
//   busy     : frame in progress or FIFO not empty
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int          DATA_LENGTH = 32,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DIV_RST     = 16'd16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_port_if.slave  bus,
  output logic           tx,
  output logic           busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                   wr_en;
  logic                   rd_en;
  logic [1:0]             reg_sel;
  logic                   push;
  logic                   pop;
  logic [7:0]             fifo_dout;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic [15:0]            div_reg;
  logic [DATA_LENGTH-1:0] rd_data;

  frame_state_e state;
  logic [7:0]   shift;
  logic [15:0]  div_q;
  logic [15:0]  baud_cnt;
  logic [2:0]   bit_idx;
  logic         baud_done;

  // Address bits outside [3:2] and the upper write-data bits are not decoded.
  logic unused_bus;
  assign unused_bus = ^{bus.Address[DATA_LENGTH-1:4], bus.Address[1:0],
                        bus.DataIn[DATA_LENGTH-1:16]};

  assign wr_en   = bus.Select & bus.MemWrite;
  assign rd_en   = bus.Select & bus.MemRead;
  assign reg_sel = bus.Address[3:2];
  assign push    = wr_en && (reg_sel == UART_TXDATA);

  assign baud_done = (baud_cnt == '0);
  // Pop whenever the engine can start a frame this edge: from IDLE, or at
  // the end of STOP so consecutive frames abut.
  assign pop = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));
  assign busy = (state != ST_IDLE) | ~empty;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.DataIn[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Registers: overflow sticky, DIV with 0 coerced to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      div_reg  <= DIV_RST;
    end else begin
      if (push && full)
        overflow <= 1'b1;
      else if (wr_en && (reg_sel == UART_STATUS) && bus.DataIn[STAT_OVF])
        overflow <= 1'b0;
      if (wr_en && (reg_sel == UART_DIV))
        div_reg <= (bus.DataIn[15:0] == 16'd0) ? 16'd1 : bus.DataIn[15:0];
    end
  end

  // Frame engine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      div_q    <= DIV_RST;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= fifo_dout;
            div_q    <= div_reg;
            baud_cnt <= div_reg - 16'd1;
            tx       <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= div_q - 16'd1;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= div_q - 16'd1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift    <= fifo_dout;
              div_q    <= div_reg;
              baud_cnt <= div_reg - 16'd1;
              tx       <= 1'b0;
              state    <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux, zero when not selected for read
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (reg_sel)
        UART_STATUS: begin
          rd_data[STAT_BUSY]            = busy;
          rd_data[STAT_FULL]            = full;
          rd_data[STAT_EMPTY]           = empty;
          rd_data[STAT_OVF]             = overflow;
          rd_data[STAT_CNT_LSB +: CW]   = count;
        end
        UART_DIV: rd_data[15:0] = div_reg;
        default:  rd_data = '0;
      endcase
    end
  end

  assign bus.DataOut = rd_data;
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port
// Self-checking bench: a timeline reference model (byte queue, frame start
// cycle, latched divisor) predicts tx, busy and register reads every cycle.
module tb_uart_tx_port;
  import uart_tx_port_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic busy;

  uart_tx_port_if #(.DATA_LENGTH(32)) bus ();

  uart_tx_port #(
    .DATA_LENGTH (32),
    .FIFO_DEPTH  (DEPTH),
    .DIV_RST     (16'd16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q [$];
  logic       m_ovf;
  int         m_div;
  logic       m_in_frame;
  logic [7:0] m_byte;
  int         m_d;
  int         m_start;
  int         m_cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ovf      = 1'b0;
      m_div      = 16;
      m_in_frame = 1'b0;
      m_byte     = '0;
      m_d        = 16;
      m_start    = 0;
      m_cyc      = 0;
    end else begin
      int  sz;
      logic was_full;
      m_cyc++;
      sz       = m_q.size();
      was_full = (sz == DEPTH);
      if (m_in_frame && (m_cyc - m_start == 10 * m_d)) m_in_frame = 1'b0;
      if (!m_in_frame && sz > 0) begin
        m_byte     = m_q.pop_front();
        m_d        = m_div;
        m_start    = m_cyc;
        m_in_frame = 1'b1;
      end
      if (bus.Select && bus.MemWrite) begin
        case (bus.Address[3:2])
          UART_TXDATA: if (was_full) m_ovf = 1'b1; else m_q.push_back(bus.DataIn[7:0]);
          UART_STATUS: if (bus.DataIn[3]) m_ovf = 1'b0;
          UART_DIV:    m_div = (bus.DataIn[15:0] == 16'd0) ? 1 : int'(bus.DataIn[15:0]);
          default:     ;
        endcase
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_in_frame) return 1'b1;
    k = (m_cyc - m_start) / m_d;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return m_in_frame || (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    logic [31:0] v;
    int sz;
    v  = '0;
    sz = m_q.size();
    case (idx)
      UART_STATUS: begin
        v[0]   = exp_busy();
        v[1]   = (sz == DEPTH);
        v[2]   = (sz == 0);
        v[3]   = m_ovf;
        v[6:4] = sz[2:0];
      end
      UART_DIV: v[15:0] = m_div[15:0];
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Cycle-by-cycle line and busy comparison
  always @(negedge clk) begin
    if (!rst) begin
      check("tx", {31'd0, tx}, {31'd0, exp_tx()});
      check("busy", {31'd0, busy}, {31'd0, exp_busy()});
    end
  end

  // ---------------- bus tasks (entered on a falling edge) ----------------
  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    bus.Address  = {28'd0, idx, 2'b00};
    bus.DataIn   = data;
    bus.Select   = 1'b1;
    bus.MemWrite = 1'b1;
    @(negedge clk);
    bus.Select   = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] idx, input string tag, output logic [31:0] val);
    bus.Address = {28'd0, idx, 2'b00};
    bus.Select  = 1'b1;
    bus.MemRead = 1'b1;
    #1;
    val = bus.DataOut;
    check(tag, val, model_read(idx));
    @(negedge clk);
    bus.Select  = 1'b0;
    bus.MemRead = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Called right after a TXDATA write to an idle engine: expects tx to fall
  // on the next edge, then counts busy cycles and samples each bit.
  task automatic measure(input int d, output int n, output logic [7:0] b);
    @(negedge clk);
    check("frame_start", {31'd0, tx}, 32'd0);
    n = 0;
    b = '0;
    while (busy && n < 3000) begin
      if (n >= d && n < 9 * d && (n % d) == 0) b[(n / d) - 1] = tx;
      @(negedge clk);
      n++;
    end
  endtask

  logic [31:0] val;
  int          len;
  logic [7:0]  got_byte;
  int          lows;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Address  = '0;
    bus.DataIn   = '0;
    bus.Select   = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dout", bus.DataOut, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(UART_STATUS, "rst_status", val);
    check("rst_status_const", val, 32'h4);
    bus_read(UART_DIV, "rst_div", val);
    check("rst_div_const", val, 32'd16);

    // Single byte at DIV=4
    bus_write(UART_DIV, 32'd4);
    bus_write(UART_TXDATA, 32'hA5);
    check("t1_pre_tx", {31'd0, tx}, 32'd1);
    measure(4, len, got_byte);
    check("t1_len", len, 32'd40);
    check("t1_byte", {24'd0, got_byte}, 32'hA5);

    // FIFO fill and overflow at DIV=2: first byte leaves on the next edge,
    // four more fill the FIFO, the sixth is dropped.
    bus_write(UART_DIV, 32'd2);
    for (int i = 1; i <= 6; i++) bus_write(UART_TXDATA, i);
    bus_read(UART_STATUS, "t2_status", val);
    check("t2_ovf", {31'd0, val[3]}, 32'd1);
    check("t2_full", {31'd0, val[1]}, 32'd1);
    bus_write(UART_STATUS, 32'h8);
    bus_read(UART_STATUS, "t2_status_clr", val);
    check("t2_ovf_clr", {31'd0, val[3]}, 32'd0);
    wait_idle();

    // DIV=0 coerced to 1
    bus_write(UART_DIV, 32'd0);
    bus_read(UART_DIV, "t3_div", val);
    check("t3_div_const", val, 32'd1);
    bus_write(UART_TXDATA, 32'h55);
    measure(1, len, got_byte);
    check("t3_len", len, 32'd10);
    check("t3_byte", {24'd0, got_byte}, 32'h55);

    // DIV change mid-frame applies at the next pop
    bus_write(UART_DIV, 32'd4);
    bus_write(UART_TXDATA, 32'h3C);
    bus_write(UART_TXDATA, 32'hC3);
    repeat (10) @(negedge clk);
    bus_write(UART_DIV, 32'd8);
    wait_idle();

    // Register reads
    bus.MemRead = 1'b1;
    for (int unsigned a = 0; a < 4; a++) begin
      bus.Address = a << 2;
      #1;
      check("nosel_dout", bus.DataOut, 32'd0);
    end
    @(negedge clk);
    bus.MemRead = 1'b0;
    bus_read(UART_RSVD, "rsvd_read", val);
    check("rsvd_const", val, 32'd0);
    bus_read(UART_TXDATA, "txdata_read", val);
    check("txdata_const", val, 32'd0);
    bus_write(UART_RSVD, 32'hFFFF_FFFF);
    bus_read(UART_DIV, "rsvd_wr_div", val);

    // Reset mid-frame
    bus_write(UART_DIV, 32'd4);
    bus_write(UART_TXDATA, 32'h81);
    bus_write(UART_TXDATA, 32'h42);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    bus_read(UART_STATUS, "post_rst_status", val);
    check("post_rst_status_const", val, 32'h4);
    bus_read(UART_DIV, "post_rst_div", val);
    check("post_rst_div_const", val, 32'd16);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("no_residual", lows, 32'd0);

    // Randomized traffic
    bus_write(UART_DIV, 32'd2);
    repeat (400) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      bus_write(UART_TXDATA, $urandom_range(0, 255));
      else if (r < 50) bus_write(UART_DIV, $urandom_range(0, 4));
      else if (r < 55) bus_write(UART_STATUS, $urandom_range(0, 15));
      else if (r < 58) bus_write(UART_RSVD, $urandom);
      else if (r < 80) bus_read(2'($urandom_range(0, 3)), "rnd_read", val);
      else             repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    wait_idle();
    bus_read(UART_STATUS, "final_status", val);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
